// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, buffer entries
// and the NOP that is presented while no real instruction is available.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch unit
// (master) and instruction memory (slave).
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetch entries with push/pop/clear; a simultaneous
// push and pop on a full FIFO is accepted and leaves the count unchanged.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited memory
// requests, buffers returned words and presents them to the IF/ID register.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  if_fetch_unit_if.master         imem,
  input  logic                    stall_f,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic [31:0]             pc_out,
  output logic [31:0]             instr_out,
  output logic                    instr_valid
);

  localparam int          CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(MAX_OUTSTANDING);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic          req_hold;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_next;

  fetch_entry_t  buf_head;
  fetch_entry_t  buf_push_data;
  fetch_entry_t  pcq_head;
  fetch_entry_t  pcq_push_data;
  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] out_cnt;
  logic          buf_full, buf_empty, pcq_full, pcq_empty;

  logic          pop_raw, buf_pop, buf_push, gnt_fire, credit_ok;
  logic [CW:0]   inflight_after;
  logic          unused_bits;

  // The in-flight PC queue doubles as the outstanding-request counter.
  assign pop_raw   = !buf_empty && !stall_f;
  assign credit_ok = ({1'b0, out_cnt} + {1'b0, buf_cnt}) < (CREDITS + (CW + 1)'(pop_raw));

  assign imem.imem_req  = (state == RUN) && (req_hold || credit_ok);
  assign imem.imem_addr = fetch_pc;
  assign gnt_fire       = imem.imem_req && imem.imem_gnt;

  assign buf_pop  = pop_raw && !redirect_valid;
  assign buf_push = imem.imem_rvalid && (drop_cnt == '0) && !redirect_valid;

  assign inflight_after = {1'b0, out_cnt} + (CW + 1)'(gnt_fire) - (CW + 1)'(imem.imem_rvalid);
  assign drop_next      = (imem.imem_rvalid && (drop_cnt != '0)) ? drop_cnt - 1'b1 : drop_cnt;

  assign pcq_push_data = {fetch_pc, 32'h0};
  assign buf_push_data = {pcq_head.pc, imem.imem_rdata};

  assign instr_valid = !buf_empty;
  assign pc_out      = buf_empty ? 32'h0 : buf_head.pc;
  assign instr_out   = buf_empty ? NOP_INSTR : buf_head.instr;

  assign unused_bits = ^{buf_full, pcq_full, pcq_empty, pcq_head.instr, redirect_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      req_hold <= 1'b0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight (including a grant this cycle) is stale.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      req_hold <= 1'b0;
      drop_cnt <= inflight_after[CW-1:0];
      state    <= (inflight_after == '0) ? RUN : DRAIN;
    end else begin
      req_hold <= imem.imem_req && !imem.imem_gnt;
      drop_cnt <= drop_next;
      if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
      case (state)
        BOOT:    state <= RUN;
        DRAIN:   if (drop_next == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  fetch_buffer #(.DEPTH(MAX_OUTSTANDING)) u_pres_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_cnt),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Stale entries are not cleared on redirect; they retire with their responses.
  fetch_buffer #(.DEPTH(MAX_OUTSTANDING)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (gnt_fire),
    .push_data (pcq_push_data),
    .pop       (imem.imem_rvalid),
    .head      (pcq_head),
    .count     (out_cnt),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural instruction memory
// (programmable grant delay and response latency, data = addr + 0x100).
module tb_if_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;
  int gnt_delay = 0;
  int rsp_lat = 1;
  int wait_cnt;
  int grant_cnt = 0;

  logic [2:0]  sh_v;
  logic [31:0] sh_a [3];
  logic [31:0] rsp_addr;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .stall_f        (stall_f),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  assign bus.imem_gnt    = bus.imem_req && (wait_cnt >= gnt_delay);
  assign bus.imem_rvalid = (rsp_lat == 3) ? sh_v[2] : (rsp_lat == 2) ? sh_v[1] : sh_v[0];
  assign rsp_addr        = (rsp_lat == 3) ? sh_a[2] : (rsp_lat == 2) ? sh_a[1] : sh_a[0];
  assign bus.imem_rdata  = rsp_addr + 32'h100;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_v     <= '0;
      sh_a[0]  <= '0;
      sh_a[1]  <= '0;
      sh_a[2]  <= '0;
      wait_cnt <= 0;
    end else begin
      sh_v     <= {sh_v[1:0], bus.imem_req && bus.imem_gnt};
      sh_a[0]  <= bus.imem_addr;
      sh_a[1]  <= sh_a[0];
      sh_a[2]  <= sh_a[1];
      wait_cnt <= (bus.imem_req && !bus.imem_gnt) ? wait_cnt + 1 : 0;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.imem_req && bus.imem_gnt) grant_cnt <= grant_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {31'h0, instr_valid}, {31'h0, v});
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_instr"}, instr_out, ins);
  endtask

  task automatic do_reset(input int lat, input int gdel);
    rst = 1'b1;
    rsp_lat = lat;
    gnt_delay = gdel;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int          g0;
    int          got;
    logic [31:0] exp_pc;
    logic        prev_pend;
    logic [31:0] prev_addr;

    rst = 1'b1;
    stall_f = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();

    // Reset state, then boot timing with zero-wait memory
    chk("rst_req", {31'h0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk_out("rst", 1'b0, 32'h0, NOP_INSTR);
    rst = 1'b0;
    #1;
    chk("boot_req", {31'h0, bus.imem_req}, 32'd0);
    step();
    chk("c1_req", {31'h0, bus.imem_req}, 32'd1);
    chk("c1_addr", bus.imem_addr, 32'h0);
    chk("c1_valid", {31'h0, instr_valid}, 32'd0);
    step();
    chk("c2_valid", {31'h0, instr_valid}, 32'd0);
    step();
    chk_out("c3", 1'b1, 32'h0, 32'h100);
    step();
    chk_out("c4", 1'b1, 32'h4, 32'h104);
    step();
    chk_out("c5", 1'b1, 32'h8, 32'h108);

    // Stall five cycles at pc 0x8
    stall_f = 1'b1;
    g0 = grant_cnt;
    for (int i = 0; i < 5; i++) begin
      chk_out("stall", 1'b1, 32'h8, 32'h108);
      step();
    end
    chk_out("stall_end", 1'b1, 32'h8, 32'h108);
    chk("stall_grants_le2", {31'h0, (grant_cnt - g0) <= 2}, 32'd1);
    stall_f = 1'b0;
    step();
    chk_out("rel1", 1'b1, 32'hC, 32'h10C);
    step();
    chk_out("rel2", 1'b1, 32'h10, 32'h110);

    // Asynchronous reset mid-operation
    #3;
    rst = 1'b1;
    gnt_delay = 3;
    #1;
    chk("arst_req", {31'h0, bus.imem_req}, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk_out("arst", 1'b0, 32'h0, NOP_INSTR);
    step();
    rst = 1'b0;

    // Three-cycle grant delay
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("gd_req", {31'h0, bus.imem_req}, 32'd1);
      chk("gd_addr", bus.imem_addr, 32'h0);
      chk("gd_gnt", {31'h0, bus.imem_gnt}, 32'd0);
    end
    step();
    chk("gd_gnt4", {31'h0, bus.imem_gnt}, 32'd1);
    chk("gd_addr4", bus.imem_addr, 32'h0);
    got = 0;
    exp_pc = 32'h0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      step();
      if (prev_pend) begin
        chk("gd_hold_req", {31'h0, bus.imem_req}, 32'd1);
        chk("gd_hold_addr", bus.imem_addr, prev_addr);
      end
      prev_pend = bus.imem_req && !bus.imem_gnt;
      prev_addr = bus.imem_addr;
      if (instr_valid) begin
        chk("gd_seq_pc", pc_out, exp_pc);
        chk("gd_seq_instr", instr_out, exp_pc + 32'h100);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    chk("gd_count", got, 32'd3);

    // Redirect with two responses in flight (3-cycle response latency)
    do_reset(3, 0);
    step();
    chk("rd_c1_addr", bus.imem_addr, 32'h0);
    step();
    chk("rd_c2_req", {31'h0, bus.imem_req}, 32'd1);
    chk("rd_c2_addr", bus.imem_addr, 32'h4);
    step();
    chk("rd_c3_credit", {31'h0, bus.imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    chk("rd_c4_valid", {31'h0, instr_valid}, 32'd0);
    chk("rd_c4_req", {31'h0, bus.imem_req}, 32'd0);
    chk("rd_c4_addr", bus.imem_addr, 32'h200);
    step();
    chk("rd_c5_valid", {31'h0, instr_valid}, 32'd0);
    chk("rd_c5_req", {31'h0, bus.imem_req}, 32'd0);
    step();
    chk("rd_c6_req", {31'h0, bus.imem_req}, 32'd1);
    chk("rd_c6_addr", bus.imem_addr, 32'h200);
    for (int i = 0; i < 4; i++) begin
      chk("rd_gap_valid", {31'h0, instr_valid}, 32'd0);
      step();
    end
    chk_out("rd_tgt", 1'b1, 32'h200, 32'h300);
    step();
    chk_out("rd_next", 1'b1, 32'h204, 32'h304);

    // Redirect coincident with rvalid and stall
    do_reset(1, 0);
    step();
    step();
    step();
    chk_out("rs_c3", 1'b1, 32'h0, 32'h100);
    chk("rs_c3_rvalid", {31'h0, bus.imem_rvalid}, 32'd1);
    stall_f = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    step();
    stall_f = 1'b0;
    redirect_valid = 1'b0;
    chk("rs_c4_valid", {31'h0, instr_valid}, 32'd0);
    chk("rs_c4_req", {31'h0, bus.imem_req}, 32'd1);
    chk("rs_c4_addr", bus.imem_addr, 32'h400);
    step();
    chk("rs_c5_valid", {31'h0, instr_valid}, 32'd0);
    step();
    chk_out("rs_tgt", 1'b1, 32'h400, 32'h500);
    step();
    chk_out("rs_next", 1'b1, 32'h404, 32'h504);

    // Second redirect while draining
    do_reset(3, 0);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h300;
    chk("dd_c4_valid", {31'h0, instr_valid}, 32'd0);
    chk("dd_c4_req", {31'h0, bus.imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("dd_c5_req", {31'h0, bus.imem_req}, 32'd0);
    chk("dd_c5_valid", {31'h0, instr_valid}, 32'd0);
    step();
    chk("dd_c6_req", {31'h0, bus.imem_req}, 32'd1);
    chk("dd_c6_addr", bus.imem_addr, 32'h300);
    for (int i = 0; i < 4; i++) begin
      chk("dd_gap_valid", {31'h0, instr_valid}, 32'd0);
      step();
    end
    chk_out("dd_tgt", 1'b1, 32'h300, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that drives the IF/ID pipeline register. It owns the PC and issues requests to instruction memory over a request/grant/response handshake, with up to two requests in flight. Returned words are buffered in a 2-entry queue and presented as {pc, instr, valid} to the IF/ID register, honouring stalls from the hazard unit and redirects from branch/jump resolution.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `MAX_OUTSTANDING`, default 2: in-flight plus buffered credit limit; the buffer depth equals this value.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, word-aligned (bits [1:0] = 0).
- `imem_gnt`  in  1  request accepted this cycle when `imem_req && imem_gnt`.
- `imem_rvalid`  in  1  response valid; in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  response instruction word.
- `stall_f`  in  1  hold the presented instruction; IF/ID does not load.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  target address; bits [1:0] ignored and forced to 0.
- `pc_out`  out  32  PC of the presented instruction.
- `instr_out`  out  32  presented instruction.
- `instr_valid`  out  1  `pc_out`/`instr_out` hold a real fetched instruction.

## Operation
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `pc_out`=0, `instr_out`=32'h0000_0013 (NOP), `instr_valid`=0. Fetch PC=RESET_PC. Buffer, outstanding count and drop count are 0. State=BOOT.
- States:
  - BOOT: one cycle, no request. Moves to RUN.
  - RUN: normal fetching.
  - DRAIN: discarding stale responses; no requests. Moves to RUN when the drop count reaches 0 and no redirect arrives that cycle.
- Request rule (RUN only): assert `imem_req` when outstanding + buffered − pop_this_cycle < MAX_OUTSTANDING.
  - Once `imem_req` is asserted, hold it and `imem_addr` stable until grant, except on redirect.
  - On grant: fetch PC += 4 (wraps modulo 2^32) and outstanding += 1.
- Response: `imem_rvalid` decrements outstanding.
  - If drop count > 0, the word is discarded and the drop count decrements.
  - Otherwise push {PC of that request, `imem_rdata`}. The PC is tracked by a per-request PC queue.
- Pop: the buffer head is presented. It pops when `instr_valid && !stall_f`. An empty buffer presents NOP with `instr_valid`=0.
- Redirect has priority over stall and over any same-cycle push or pop.
  - Buffer cleared, fetch PC ← `redirect_pc`.
  - Drop count ← all in-flight requests, i.e. outstanding after this cycle's grant, minus this cycle's rvalid.
  - Next state is DRAIN if the drop count is non-zero, else RUN.
  - An ungranted pending request is withdrawn; the next request uses the new address.
- Redirect in DRAIN: same update. The drop count becomes all current in-flight requests.
- A simultaneous push and pop on a full buffer is legal; the count is unchanged.

## Timing
- Zero-wait memory (same-cycle `imem_gnt`, `imem_rvalid` the next cycle): a request granted in cycle N returns in N+1 and appears on `instr_out` in N+2.
  - First valid instruction after `rst` deasserts: cycle 3 (BOOT, request, response, present).
- Sustained throughput is 1 instruction/cycle with zero-wait memory and no stall.
- `stall_f` held: outputs are frozen, the buffer fills, and requests stop at MAX_OUTSTANDING credits.
- Redirect in cycle R:
  - `instr_valid`=0 from R+1.
  - First request to the target is in R+1, or the cycle after drain completes.
  - The target instruction is presented no earlier than R+3.
- `rst` is asserted asynchronously mid-operation. All state returns to reset values immediately. Instruction memory shares `rst`, so no responses arrive after reset.

## Structure
- `fetch_pkg` contains:
  - `fetch_state_t` enum {BOOT, RUN, DRAIN}
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}
  - `NOP_INSTR` = 32'h0000_0013
- Sub-module `fetch_buffer`: parameterised-depth FIFO of `fetch_entry_t` with push/pop/clear, count, full/empty. Two instances: the presentation buffer, and the in-flight PC queue (its clear is not used by redirect; stale entries drain with the drop count).
- Top: FSM, PC register, credit logic, drop counter.

## Test plan
- Reset release with a zero-wait memory returning `addr`+0x100 as data: expect `pc_out`=0x0 and `instr_out`=0x100 at cycle 3, then pc 0x4, 0x8 on consecutive cycles.
- Memory with 3-cycle `imem_gnt` delay: `imem_addr` stays stable while `imem_req` is high and ungranted; the in-order pc/instr sequence is correct.
- `stall_f` high for 5 cycles at pc 0x8: outputs frozen, at most 2 requests issued, no lost or duplicated instruction after release (0x8, 0xC, 0x10).
- Redirect to 0x200 with 2 responses in flight: both discarded, `instr_valid`=0 until the 0x200 instruction is presented, next pc 0x204.
- Redirect coincident with `imem_rvalid` and `stall_f`: the response is dropped, redirect wins, and the first valid pc is the target.
- Second redirect during DRAIN (0x200 then 0x300): no instruction from 0x200 is ever presented; the first valid pc is 0x300.
